csr_unit: RTL and testbench
===========================

# csr_unit

Machine-mode CSR file and trap controller for the RV32IM core. It sits in the EX stage as the responder to the CSR/`mret` control bundle that ID decodes. It executes CSR read-modify-write operations, arbitrates interrupts, illegal-instruction exceptions and `mret`, and supplies the PC redirect target. The `mcycle`/`minstret` counters are optional.

## Interface
Parameters:
- RESET_MTVEC, 32'h0000_0000, reset value of `mtvec`
- HART_ID, 32'h0, value returned by `mhartid`

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk_i  in  1  clock
  - rst_i  in  1  synchronous active-high reset
- Instruction context:
  - valid_i  in  1  an EX instruction is present and not stalled
  - pc_i  in  32  PC of the EX instruction
  - instr_i  in  32  raw EX instruction
  - instr_illegal_i  in  1  decoder illegal flag
- CSR command bundle:
  - csr_addr_i  in  12  CSR address
  - csr_read_i  in  1  CSR read enable
  - csr_write_i  in  1  CSR write enable
  - csr_op_inv_i  in  1  clear operation (`csrrc`/`csrrci`)
  - csr_no_cal_i  in  1  plain write (`csrrw`/`csrrwi`)
  - csr_zimm_en_i  in  1  select zero-extended immediate as operand
  - csr_zimm_i  in  32  zero-extended immediate
  - rs1_data_i  in  32  rs1 register value
  - src_field_i  in  5  instr[19:15]
  - mret_i  in  1  `mret` instruction
- Retire and interrupt inputs:
  - retire_i  in  1  an instruction retires this cycle
  - ext_irq_i  in  1  machine external interrupt request, level
  - tmr_irq_i  in  1  machine timer interrupt request, level
- Outputs:
  - csr_rdata_o  out  32  old CSR value for write-back (combinational)
  - trap_o  out  1  take trap, flush and redirect (combinational)
  - mret_o  out  1  return, redirect (combinational)
  - redirect_pc_o  out  32  target PC when `trap_o` or `mret_o` is high
  - csr_illegal_o  out  1  illegal CSR access (included in the trap cause)

## Operation
- **Implemented CSRs.** `mstatus` 300, `misa` 301, `mie` 304, `mtvec` 305, `mscratch` 340, `mepc` 341, `mcause` 342, `mtval` 343, `mip` 344, `mhartid` F14, plus the counters (see Configuration).
- **Read-only values.**
  - `misa` reads 32'h4000_1100.
  - `mhartid` reads HART_ID.
  - `mip` bit 11 = registered `ext_irq_i`, bit 7 = registered `tmr_irq_i`. Software writes to `mip` are ignored.
- **Field rules.**
  - `mstatus`: only MIE (bit 3) and MPIE (bit 7) are writable. MPP (bits 12:11) always reads 2'b11; every other bit reads 0.
  - `mie`: only MEIE (bit 11) and MTIE (bit 7) are writable.
  - `mepc`: bits [1:0] read 0.
  - `mtvec`: bit 1 reads 0. Bit 0 = 1 selects vectored mode.
- **Operand.** op = `csr_zimm_en_i` ? `csr_zimm_i` : `rs1_data_i`.
- **New value.**
  - `csr_no_cal_i` = 1: new = op.
  - `csr_op_inv_i` = 1: new = old & ~op.
  - Otherwise: new = old | op.
- **Effective write** = `valid_i` & `csr_write_i` & (`csr_no_cal_i` | `src_field_i` != 0). No trap may be taken in the same cycle.
- **`csr_illegal_o`** = `valid_i` & `csr_read_i` & (address unimplemented | (addr[11:10] == 2'b11 & effective write)).
- **Event priority, evaluated only when `valid_i` = 1:**
  1. Exception, when `instr_illegal_i` | `csr_illegal_o`.
  2. Interrupt, when MIE & ((mip & mie) != 0). External beats timer.
  3. `mret`.
  4. CSR write.
  - A lower-priority event is suppressed when a higher one fires.
- **Trap entry.**
  - Writes: `mepc` <= `pc_i`; MPIE <= MIE; MIE <= 0.
  - `mcause`: 32'd2 for an illegal instruction, 32'h8000_000B for external, 32'h8000_0007 for timer.
  - `mtval`: `instr_i` for an illegal instruction, 0 otherwise.
  - On an interrupt, the EX instruction is squashed and does not retire; `mepc` points at it.
- **Trap target.** `redirect_pc_o` = {mtvec[31:2], 2'b00}. In vectored mode, an interrupt adds 4 × cause[3:0].
- **`mret`.** MIE <= MPIE; MPIE <= 1; `redirect_pc_o` = `mepc`.

## Timing
- `csr_rdata_o`, `trap_o`, `mret_o`, `redirect_pc_o` and `csr_illegal_o` are combinational in the same cycle as `valid_i`.
- All CSR state updates land at the next rising edge.
- `csr_rdata_o` returns the pre-write value, so a read-modify-write completes in one cycle. A back-to-back read sees the new value.
- IRQ inputs pass through one register stage:
  - A request asserted at edge N can be taken in cycle N+1.
  - Deasserting the request removes it after one cycle.
- **Reset values.**
  - `mstatus` reads 32'h0000_1800; `mtvec` = RESET_MTVEC; every other CSR and the IRQ flops are 0.
  - All outputs are 0 except `csr_rdata_o`, which follows its inputs.
- **Reset mid-operation.** Reset overrides any trap, write or counter increment in the same cycle.
- **`valid_i` = 0.** No trap, `mret` or write occurs; the counters still run.

## Configuration
- Macro: `CSR_COUNTER_EN`.
- **Defined:**
  - 64-bit `mcycle` (B00 low half, B80 high half) increments every cycle.
  - 64-bit `minstret` (B02 low half, B82 high half) increments when `retire_i` = 1.
  - The low half carries into the high half; all-ones wraps to 0.
  - A software write to a half replaces that half's increment in that cycle; the other half still takes any carry.
- **Undefined:** these four addresses are unimplemented and raise `csr_illegal_o`.

## Test plan
- Reset, then read `mstatus`, `mtvec` and `misa` → 0x1800, RESET_MTVEC, 0x40001100.
- `csrrw` `mscratch` with rs1 = 0xDEADBEEF, then `csrrs` with src_field = 0 → second read returns 0xDEADBEEF and the value is unchanged. Then `csrrci` with zimm = 0xF → `mscratch` = 0xDEADBEE0.
- Set MIE and MEIE, then raise `ext_irq_i` → `trap_o` one cycle later; `mcause` = 0x8000000B, `mepc` = `pc_i`, MIE = 0, MPIE = 1. Then `mret` → `redirect_pc_o` = `mepc`, MIE = 1.
- Illegal instruction and pending interrupt in the same cycle → cause 2, `mtval` = `instr_i`. Write to `mhartid` → `csr_illegal_o` = 1 and the value is unchanged.
- `mtvec` = 0x101 (vectored), timer interrupt → `redirect_pc_o` = 0x11C.
- With `CSR_COUNTER_EN`: write `mcycle` = 0xFFFFFFFF → `mcycleh` increments on the next cycle. Without it: reading B00 → `csr_illegal_o` = 1.

Source files
------------

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap controller for the RV32IM EX stage.
// Optional mcycle/minstret counters are built when CSR_COUNTER_EN is defined.
module csr_unit #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        instr_illegal_i,
  input  logic [11:0] csr_addr_i,
  input  logic        csr_read_i,
  input  logic        csr_write_i,
  input  logic        csr_op_inv_i,
  input  logic        csr_no_cal_i,
  input  logic        csr_zimm_en_i,
  input  logic [31:0] csr_zimm_i,
  input  logic [31:0] rs1_data_i,
  input  logic [4:0]  src_field_i,
  input  logic        mret_i,
  input  logic        retire_i,
  input  logic        ext_irq_i,
  input  logic        tmr_irq_i,
  output logic [31:0] csr_rdata_o,
  output logic        trap_o,
  output logic        mret_o,
  output logic [31:0] redirect_pc_o,
  output logic        csr_illegal_o
);

  localparam logic [31:0] MISA_VAL = 32'h4000_1100;

  logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic        meie_q, meie_d, mtie_q, mtie_d;
  logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic        ext_q, tmr_q;

  logic [31:0] old_val, operand, new_val, cause, trap_pc;
  logic        addr_ok, eff_write, csr_illegal, exc, irq_take, trap, mret_take, do_write;
  logic        ext_pend, tmr_pend;

`ifdef CSR_COUNTER_EN
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [31:0] cyc_lo, ins_lo;
  logic        cyc_c, ins_c;
  logic        unused_ok;
  assign unused_ok = ^pc_i[1:0];
`else
  logic        unused_ok;
  assign unused_ok = ^{pc_i[1:0], retire_i};
`endif

  // NOTE: every output of a combinational block gets a default before the
  // case/if tree, so no path leaves a value held and no latch is inferred.
  always_comb begin
    old_val = 32'h0;
    addr_ok = 1'b1;
    case (csr_addr_i)
      12'h300: old_val = {19'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
      12'h301: old_val = MISA_VAL;
      12'h304: old_val = {20'b0, meie_q, 3'b0, mtie_q, 7'b0};
      12'h305: old_val = mtvec_q;
      12'h340: old_val = mscratch_q;
      12'h341: old_val = mepc_q;
      12'h342: old_val = mcause_q;
      12'h343: old_val = mtval_q;
      12'h344: old_val = {20'b0, ext_q, 3'b0, tmr_q, 7'b0};
      12'hF14: old_val = HART_ID;
`ifdef CSR_COUNTER_EN
      12'hB00: old_val = mcycle_q[31:0];
      12'hB80: old_val = mcycle_q[63:32];
      12'hB02: old_val = minstret_q[31:0];
      12'hB82: old_val = minstret_q[63:32];
`endif
      default: addr_ok = 1'b0;
    endcase
  end

  // Event arbitration: exception > interrupt > mret > CSR write.
  always_comb begin
    operand     = csr_zimm_en_i ? csr_zimm_i : rs1_data_i;
    new_val     = csr_no_cal_i ? operand :
                  csr_op_inv_i ? (old_val & ~operand) : (old_val | operand);
    eff_write   = valid_i & csr_write_i & (csr_no_cal_i | (src_field_i != 5'd0));
    csr_illegal = valid_i & csr_read_i &
                  (~addr_ok | ((csr_addr_i[11:10] == 2'b11) & eff_write));
    ext_pend    = ext_q & meie_q;
    tmr_pend    = tmr_q & mtie_q;
    exc         = valid_i & (instr_illegal_i | csr_illegal);
    irq_take    = valid_i & ~exc & mst_mie_q & (ext_pend | tmr_pend);
    trap        = exc | irq_take;
    mret_take   = valid_i & mret_i & ~trap;
    do_write    = eff_write & ~trap & ~mret_take;
    cause       = exc ? 32'd2 : (ext_pend ? 32'h8000_000B : 32'h8000_0007);
    trap_pc     = {mtvec_q[31:2], 2'b00} +
                  ((irq_take & mtvec_q[0]) ? {26'd0, cause[3:0], 2'b00} : 32'd0);
  end

  assign csr_rdata_o   = old_val;
  assign trap_o        = ~rst_i & trap;
  assign mret_o        = ~rst_i & mret_take;
  assign csr_illegal_o = ~rst_i & csr_illegal;
  assign redirect_pc_o = rst_i     ? 32'd0 :
                         trap      ? trap_pc :
                         mret_take ? {mepc_q[31:2], 2'b00} : 32'd0;

  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    meie_d     = meie_q;
    mtie_d     = mtie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (trap) begin
      mepc_d     = {pc_i[31:2], 2'b00};
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
      mcause_d   = cause;
      mtval_d    = exc ? instr_i : 32'd0;
    end else if (mret_take) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end else if (do_write) begin
      case (csr_addr_i)
        12'h300: begin
          mst_mie_d  = new_val[3];
          mst_mpie_d = new_val[7];
        end
        12'h304: begin
          meie_d = new_val[11];
          mtie_d = new_val[7];
        end
        12'h305: mtvec_d    = {new_val[31:2], 1'b0, new_val[0]};
        12'h340: mscratch_d = new_val;
        12'h341: mepc_d     = {new_val[31:2], 2'b00};
        12'h342: mcause_d   = new_val;
        12'h343: mtval_d    = new_val;
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      meie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      mtvec_q    <= RESET_MTVEC & ~32'h2;
      mscratch_q <= 32'd0;
      mepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
      mtval_q    <= 32'd0;
      ext_q      <= 1'b0;
      tmr_q      <= 1'b0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      meie_q     <= meie_d;
      mtie_q     <= mtie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      ext_q      <= ext_irq_i;
      tmr_q      <= tmr_irq_i;
    end
  end

`ifdef CSR_COUNTER_EN
  // A software write to one half replaces its increment; the other half keeps the carry.
  always_comb begin
    {cyc_c, cyc_lo} = {1'b0, mcycle_q[31:0]} + 33'd1;
    {ins_c, ins_lo} = {1'b0, minstret_q[31:0]} + {32'd0, retire_i};
    mcycle_d   = {mcycle_q[63:32] + {31'd0, cyc_c}, cyc_lo};
    minstret_d = {minstret_q[63:32] + {31'd0, ins_c}, ins_lo};
    if (do_write) begin
      case (csr_addr_i)
        12'hB00: mcycle_d[31:0]    = new_val;
        12'hB80: mcycle_d[63:32]   = new_val;
        12'hB02: minstret_d[31:0]  = new_val;
        12'hB82: minstret_d[63:32] = new_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`endif

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed vector table, then random
// stimulus compared against a behavioural CSR/trap model.
module tb_csr_unit;

  localparam logic [31:0] RST_MTVEC = 32'h0000_0200;
  localparam logic [31:0] HART      = 32'h0000_0005;
  localparam logic [31:0] TBL_INSTR = 32'h1234_5678;

  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, instr_illegal_i;
  logic [31:0] pc_i, instr_i, csr_zimm_i, rs1_data_i;
  logic [11:0] csr_addr_i;
  logic        csr_read_i, csr_write_i, csr_op_inv_i, csr_no_cal_i, csr_zimm_en_i;
  logic [4:0]  src_field_i;
  logic        mret_i, retire_i, ext_irq_i, tmr_irq_i;
  logic [31:0] csr_rdata_o, redirect_pc_o;
  logic        trap_o, mret_o, csr_illegal_o;

  always #5 clk_i = ~clk_i;

  csr_unit #(.RESET_MTVEC(RST_MTVEC), .HART_ID(HART)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i), .instr_i(instr_i),
    .instr_illegal_i(instr_illegal_i), .csr_addr_i(csr_addr_i), .csr_read_i(csr_read_i),
    .csr_write_i(csr_write_i), .csr_op_inv_i(csr_op_inv_i), .csr_no_cal_i(csr_no_cal_i),
    .csr_zimm_en_i(csr_zimm_en_i), .csr_zimm_i(csr_zimm_i), .rs1_data_i(rs1_data_i),
    .src_field_i(src_field_i), .mret_i(mret_i), .retire_i(retire_i), .ext_irq_i(ext_irq_i),
    .tmr_irq_i(tmr_irq_i), .csr_rdata_o(csr_rdata_o), .trap_o(trap_o), .mret_o(mret_o),
    .redirect_pc_o(redirect_pc_o), .csr_illegal_o(csr_illegal_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef enum {C_NONE, C_RW, C_RS, C_RC, C_RWI, C_RSI, C_RCI, C_MRET} cmd_e;

  typedef struct {
    bit          rst, valid, ill, ext, tmr;
    cmd_e        cmd;
    logic [11:0] addr;
    logic [31:0] opnd, pc;
    logic [4:0]  src;
    logic [31:0] e_rdata, e_redir;
    bit          e_trap, e_mret, e_ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit valid, cmd_e cmd, logic [11:0] addr,
                              logic [31:0] opnd, logic [4:0] src, bit ill, bit ext,
                              bit tmr, logic [31:0] pc, logic [31:0] e_rdata,
                              bit e_trap, bit e_mret, logic [31:0] e_redir, bit e_ill);
    vec_t v;
    v.rst = rst; v.valid = valid; v.cmd = cmd; v.addr = addr; v.opnd = opnd;
    v.src = src; v.ill = ill; v.ext = ext; v.tmr = tmr; v.pc = pc;
    v.e_rdata = e_rdata; v.e_trap = e_trap; v.e_mret = e_mret;
    v.e_redir = e_redir; v.e_ill = e_ill;
    return v;
  endfunction

  task automatic drive_vec(input vec_t v);
    rst_i = v.rst; valid_i = v.valid; csr_addr_i = v.addr; rs1_data_i = v.opnd;
    csr_zimm_i = v.opnd; src_field_i = v.src; instr_illegal_i = v.ill;
    ext_irq_i = v.ext; tmr_irq_i = v.tmr; pc_i = v.pc; instr_i = TBL_INSTR;
    retire_i = 1'b0;
    csr_read_i = 1'b0; csr_write_i = 1'b0; csr_op_inv_i = 1'b0;
    csr_no_cal_i = 1'b0; csr_zimm_en_i = 1'b0; mret_i = 1'b0;
    case (v.cmd)
      C_RW:   begin csr_read_i = 1; csr_write_i = 1; csr_no_cal_i = 1; end
      C_RS:   begin csr_read_i = 1; csr_write_i = 1; end
      C_RC:   begin csr_read_i = 1; csr_write_i = 1; csr_op_inv_i = 1; end
      C_RWI:  begin csr_read_i = 1; csr_write_i = 1; csr_no_cal_i = 1; csr_zimm_en_i = 1; end
      C_RSI:  begin csr_read_i = 1; csr_write_i = 1; csr_zimm_en_i = 1; end
      C_RCI:  begin csr_read_i = 1; csr_write_i = 1; csr_op_inv_i = 1; csr_zimm_en_i = 1; end
      C_MRET: mret_i = 1;
      default: ;
    endcase
  endtask

  // Behavioural model: CSRs held as plain words, field rules applied on read.
  logic [31:0] m_mst, m_mie, m_mtvec, m_mscr, m_mepc, m_mcause, m_mtval;
  bit          m_ext, m_tmr;
  logic [63:0] m_cyc, m_ins;

  function automatic void m_reset();
    m_mst = 0; m_mie = 0; m_mtvec = RST_MTVEC; m_mscr = 0; m_mepc = 0;
    m_mcause = 0; m_mtval = 0; m_ext = 0; m_tmr = 0; m_cyc = 0; m_ins = 0;
  endfunction

  function automatic bit m_read(input logic [11:0] a, output logic [31:0] v);
    v = 32'h0;
    m_read = 1'b1;
    case (a)
      12'h300: v = 32'h1800 | (m_mst & 32'h88);
      12'h301: v = 32'h4000_1100;
      12'h304: v = m_mie & 32'h880;
      12'h305: v = m_mtvec & ~32'h2;
      12'h340: v = m_mscr;
      12'h341: v = m_mepc & ~32'h3;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = (m_ext ? 32'h800 : 32'h0) | (m_tmr ? 32'h80 : 32'h0);
      12'hF14: v = HART;
`ifdef CSR_COUNTER_EN
      12'hB00: v = m_cyc[31:0];
      12'hB80: v = m_cyc[63:32];
      12'hB02: v = m_ins[31:0];
      12'hB82: v = m_ins[63:32];
`endif
      default: m_read = 1'b0;
    endcase
  endfunction

  initial begin
    logic [11:0] addrs [16];
    addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
              12'h344, 12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0, 12'h000};

    // rst valid cmd addr opnd src ill ext tmr pc | rdata trap mret redir ill
    vecs.push_back(mk(1, 0, C_NONE, 12'h300, 0, 0, 0, 0, 0, 0, 32'h1800, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RS,   12'h300, 0, 0, 0, 0, 0, 0, 32'h1800, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RS,   12'h305, 0, 0, 0, 0, 0, 0, RST_MTVEC, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RS,   12'h301, 0, 0, 0, 0, 0, 0, 32'h4000_1100, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RW,   12'h340, 32'hDEADBEEF, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RS,   12'h340, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RCI,  12'h340, 32'hF, 5'hF, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RS,   12'h340, 0, 0, 0, 0, 0, 0, 32'hDEADBEE0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RSI,  12'h300, 32'h8, 8, 0, 0, 0, 0, 32'h1800, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RS,   12'h304, 32'h800, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, C_NONE, 12'h344, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_NONE, 12'h344, 0, 0, 0, 1, 0, 32'h400, 32'h800, 1, 0, RST_MTVEC, 0));
    vecs.push_back(mk(0, 1, C_RS,   12'h342, 0, 0, 0, 0, 0, 0, 32'h8000_000B, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RS,   12'h341, 0, 0, 0, 0, 0, 0, 32'h400, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RS,   12'h300, 0, 0, 0, 0, 0, 0, 32'h1880, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_MRET, 12'h300, 0, 0, 0, 0, 0, 32'h404, 32'h1880, 0, 1, 32'h400, 0));
    vecs.push_back(mk(0, 1, C_RS,   12'h300, 0, 0, 0, 0, 0, 0, 32'h1888, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, C_NONE, 12'h340, 0, 0, 0, 1, 0, 0, 32'hDEADBEE0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_NONE, 12'h340, 0, 0, 1, 1, 0, 32'h500, 32'hDEADBEE0, 1, 0, RST_MTVEC, 0));
    vecs.push_back(mk(0, 1, C_RS,   12'h342, 0, 0, 0, 0, 0, 0, 32'd2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RS,   12'h343, 0, 0, 0, 0, 0, 0, TBL_INSTR, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RS,   12'h341, 0, 0, 0, 0, 0, 0, 32'h500, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RW,   12'hF14, 32'h77, 3, 0, 0, 0, 32'h504, HART, 1, 0, RST_MTVEC, 1));
    vecs.push_back(mk(0, 1, C_RS,   12'hF14, 0, 0, 0, 0, 0, 0, HART, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RW,   12'h305, 32'h101, 1, 0, 0, 0, 0, RST_MTVEC, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RS,   12'h304, 32'h80, 1, 0, 0, 0, 0, 32'h800, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RSI,  12'h300, 32'h8, 8, 0, 0, 0, 0, 32'h1800, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, C_NONE, 12'h305, 0, 0, 0, 0, 1, 0, 32'h101, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_NONE, 12'h344, 0, 0, 0, 0, 1, 32'h600, 32'h80, 1, 0, 32'h11C, 0));
    vecs.push_back(mk(0, 1, C_RS,   12'h342, 0, 0, 0, 0, 0, 0, 32'h8000_0007, 0, 0, 0, 0));
`ifdef CSR_COUNTER_EN
    vecs.push_back(mk(0, 1, C_RW,   12'hB00, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 32'd29, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RS,   12'hB00, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RS,   12'hB80, 0, 0, 0, 0, 0, 0, 32'd1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RS,   12'hB02, 0, 0, 0, 0, 0, 0, 32'd0, 0, 0, 0, 0));
`else
    vecs.push_back(mk(0, 1, C_RS,   12'hB00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h100, 1));
    vecs.push_back(mk(0, 1, C_RS,   12'hB80, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h100, 1));
    vecs.push_back(mk(0, 1, C_RS,   12'hB02, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h100, 1));
    vecs.push_back(mk(0, 1, C_RS,   12'hB82, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h100, 1));
`endif
    vecs.push_back(mk(1, 1, C_RW,   12'h340, 32'h55, 1, 0, 0, 0, 0, 32'hDEADBEE0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RS,   12'h340, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RS,   12'h305, 0, 0, 0, 0, 0, 0, RST_MTVEC, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RS,   12'h300, 0, 0, 0, 0, 0, 0, 32'h1800, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RW,   12'h305, 32'h103, 1, 0, 0, 0, 0, RST_MTVEC, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, C_RS,   12'h305, 0, 0, 0, 0, 0, 0, 32'h101, 0, 0, 0, 0));

    // Power-on reset for two cycles.
    drive_vec(mk(1, 0, C_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk_i);
    #1;

    foreach (vecs[i]) begin
      drive_vec(vecs[i]);
      #1;
      check($sformatf("v%0d.rdata", i), csr_rdata_o, vecs[i].e_rdata);
      check($sformatf("v%0d.trap", i), {31'd0, trap_o}, {31'd0, vecs[i].e_trap});
      check($sformatf("v%0d.mret", i), {31'd0, mret_o}, {31'd0, vecs[i].e_mret});
      check($sformatf("v%0d.redir", i), redirect_pc_o, vecs[i].e_redir);
      check($sformatf("v%0d.illegal", i), {31'd0, csr_illegal_o}, {31'd0, vecs[i].e_ill});
      @(posedge clk_i);
      #1;
    end

    // Random phase: resynchronise DUT and model with a reset cycle.
    drive_vec(mk(1, 0, C_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk_i);
    #1;
    m_reset();
    ext_irq_i = 0;
    tmr_irq_i = 0;

    for (int k = 0; k < 3000; k++) begin
      logic [31:0] old, opv, nv, cause, e_red, cyc_n, ins_n_dummy;
      logic [63:0] cyc_next, ins_next;
      bit ok, wr, e_ill, e_trap, e_mret, exc, irq, ext_p, tmr_p;

      rst_i           = ($urandom_range(0, 99) == 0);
      valid_i         = ($urandom_range(0, 3) != 0);
      csr_addr_i      = addrs[$urandom_range(0, 15)];
      csr_read_i      = ($urandom_range(0, 3) != 0);
      csr_write_i     = ($urandom_range(0, 2) != 0);
      csr_op_inv_i    = $urandom_range(0, 1);
      csr_no_cal_i    = $urandom_range(0, 1);
      csr_zimm_en_i   = $urandom_range(0, 1);
      csr_zimm_i      = {27'd0, 5'($urandom)};
      rs1_data_i      = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      src_field_i     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      mret_i          = ($urandom_range(0, 11) == 0);
      instr_illegal_i = ($urandom_range(0, 19) == 0);
      retire_i        = $urandom_range(0, 1);
      pc_i            = $urandom;
      instr_i         = $urandom;
      if ($urandom_range(0, 7) == 0) ext_irq_i = ~ext_irq_i;
      if ($urandom_range(0, 7) == 0) tmr_irq_i = ~tmr_irq_i;
      #1;

      ok    = m_read(csr_addr_i, old);
      opv   = csr_zimm_en_i ? csr_zimm_i : rs1_data_i;
      nv    = csr_no_cal_i ? opv : (csr_op_inv_i ? (old & ~opv) : (old | opv));
      wr    = valid_i && csr_write_i && (csr_no_cal_i || src_field_i != 0);
      e_ill = valid_i && csr_read_i && (!ok || (csr_addr_i[11:10] == 2'b11 && wr));
      ext_p = m_ext && m_mie[11];
      tmr_p = m_tmr && m_mie[7];
      exc   = valid_i && (instr_illegal_i || e_ill);
      irq   = valid_i && !exc && m_mst[3] && (ext_p || tmr_p);
      cause = exc ? 32'd2 : (ext_p ? 32'h8000_000B : 32'h8000_0007);
      e_trap = exc || irq;
      e_mret = valid_i && mret_i && !e_trap;
      e_red  = 0;
      if (e_trap)
        e_red = (m_mtvec & ~32'h3) + ((irq && m_mtvec[0]) ? 4 * (cause & 32'hF) : 0);
      else if (e_mret)
        e_red = m_mepc & ~32'h3;
      if (rst_i) begin
        e_trap = 0; e_mret = 0; e_ill = 0; e_red = 0;
      end

      check($sformatf("r%0d.rdata", k), csr_rdata_o, old);
      check($sformatf("r%0d.trap", k), {31'd0, trap_o}, {31'd0, e_trap});
      check($sformatf("r%0d.mret", k), {31'd0, mret_o}, {31'd0, e_mret});
      check($sformatf("r%0d.redir", k), redirect_pc_o, e_red);
      check($sformatf("r%0d.illegal", k), {31'd0, csr_illegal_o}, {31'd0, e_ill});

      if (rst_i) begin
        m_reset();
      end else begin
        cyc_next = m_cyc + 1;
        ins_next = m_ins + (retire_i ? 64'd1 : 64'd0);
        if (e_trap) begin
          m_mepc   = pc_i;
          m_mst    = m_mst[3] ? 32'h80 : 32'h0;
          m_mcause = cause;
          m_mtval  = exc ? instr_i : 32'h0;
        end else if (e_mret) begin
          m_mst = 32'h80 | (m_mst[7] ? 32'h8 : 32'h0);
        end else if (wr) begin
          case (csr_addr_i)
            12'h300: m_mst    = nv;
            12'h304: m_mie    = nv;
            12'h305: m_mtvec  = nv;
            12'h340: m_mscr   = nv;
            12'h341: m_mepc   = nv;
            12'h342: m_mcause = nv;
            12'h343: m_mtval  = nv;
`ifdef CSR_COUNTER_EN
            12'hB00: cyc_next[31:0]  = nv;
            12'hB80: cyc_next[63:32] = nv;
            12'hB02: ins_next[31:0]  = nv;
            12'hB82: ins_next[63:32] = nv;
`endif
            default: ;
          endcase
        end
        cyc_n = 0;
        ins_n_dummy = 0;
        m_cyc = cyc_next;
        m_ins = ins_next;
        m_ext = ext_irq_i;
        m_tmr = tmr_irq_i;
      end
      @(posedge clk_i);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
